// File: rtl/md_sched.sv
// rtl/md_sched.sv - HI/LO multiply/divide sequencer for the P5 pipeline
// Results are computed at issue and parked in pend_*; the down-counter only models latency.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        d_md_use,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        drop
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     pend_hi_q, pend_hi_d;
   logic [31:0]     pend_lo_q, pend_lo_d;
   logic            skip_q, skip_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic            drop_q, drop_d;

   logic [63:0]     prod_s, prod_u;
   logic            is_sdiv, a_neg, b_neg, b_zero;
   logic [31:0]     mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
   logic            long_op;

   always_comb begin
      prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u = {32'd0, A} * {32'd0, B};
   end

   // Sign-magnitude division: one unsigned divider serves both div and divu, and
   // 0x80000000 / -1 naturally yields 0x80000000 with remainder 0.
   always_comb begin
      is_sdiv = (md_op == OP_DIV);
      a_neg   = is_sdiv & A[31];
      b_neg   = is_sdiv & B[31];
      b_zero  = (B == 32'd0);
      mag_a   = a_neg ? (~A + 32'd1) : A;
      mag_b   = b_neg ? (~B + 32'd1) : B;
      div_b   = b_zero ? 32'd1 : mag_b;
      q_mag   = mag_a / div_b;
      r_mag   = mag_a % div_b;
      quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      skip_d    = skip_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      drop_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (md_op)
                  OP_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     skip_d    = 1'b0;
                     cnt_d     = CW'(MULT_CYCLES);
                     state_d   = RUN;
                  end
                  OP_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                     skip_d    = 1'b0;
                     cnt_d     = CW'(MULT_CYCLES);
                     state_d   = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     skip_d    = b_zero;
                     cnt_d     = CW'(DIV_CYCLES);
                     state_d   = RUN;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // The commit cycle is still RUN, so a start landing on it is dropped too.
            drop_d = start & (md_op != OP_NONE);
            if (cnt_q == CW'(1)) begin
               if (!skip_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         skip_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         skip_q    <= skip_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      long_op  = (md_op == OP_MULT) | (md_op == OP_MULTU) |
                 (md_op == OP_DIV)  | (md_op == OP_DIVU);
      busy     = (state_q == RUN);
      md_stall = d_md_use & (busy | (start & long_op));
      HI       = hi_q;
      LO       = lo_q;
      drop     = drop_q;
   end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - randomized and directed bench for md_sched against an arithmetic model
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        d_md_use;
   logic        busy, md_stall, drop;
   logic [31:0] HI, LO;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
      .d_md_use(d_md_use), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO),
      .drop(drop)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = sa * sb; return p; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
         3'd3: begin
            if (b == 32'd0) return {hi, lo};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return {hi, lo};
            return {a % b, a / b};
         end
         3'd5: return {a, lo};
         3'd6: return {hi, a};
         default: return {hi, lo};
      endcase
   endfunction

   function automatic int latency(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return 5;
      if (op == 3'd3 || op == 3'd4) return 10;
      return 0;
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
      logic [63:0] m;
      @(negedge clk);
      start = 1'b1; md_op = op; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         @(posedge clk); #1;
      end
      m = model(op, a, b, hi_m, lo_m);
      hi_m = m[63:32];
      lo_m = m[31:0];
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0; d_md_use = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if ({busy, drop, md_stall, HI, LO} !== 67'd0) begin
         $display("FAIL reset_state busy=%b drop=%b stall=%b HI=%h LO=%h required all 0",
                  busy, drop, md_stall, HI, LO);
      end else n_pass++;
   endtask

   task automatic test_mult;
      int cyc;
      do_op(3'd1, 32'hFFFFFFFF, 32'd2, cyc);
      n_total++;
      if (cyc != 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
         $display("FAIL mult cycles=%0d HI=%h LO=%h required 5 ffffffff fffffffe", cyc, HI, LO);
      end else n_pass++;
      do_op(3'd2, 32'hFFFFFFFF, 32'd2, cyc);
      n_total++;
      if (cyc != 5 || HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
         $display("FAIL multu cycles=%0d HI=%h LO=%h required 5 00000001 fffffffe", cyc, HI, LO);
      end else n_pass++;
   endtask

   task automatic test_div;
      int cyc;
      do_op(3'd3, -32'sd7, 32'd2, cyc);
      n_total++;
      if (cyc != 10 || LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin
         $display("FAIL div_neg cycles=%0d HI=%h LO=%h required 10 ffffffff fffffffd", cyc, HI, LO);
      end else n_pass++;
      do_op(3'd4, 32'd7, 32'd2, cyc);
      n_total++;
      if (cyc != 10 || LO !== 32'd3 || HI !== 32'd1) begin
         $display("FAIL divu cycles=%0d HI=%h LO=%h required 10 1 3", cyc, HI, LO);
      end else n_pass++;
      do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
      n_total++;
      if (LO !== 32'h80000000 || HI !== 32'd0) begin
         $display("FAIL div_ovf HI=%h LO=%h required 0 80000000", HI, LO);
      end else n_pass++;
   endtask

   task automatic test_div_zero;
      int cyc;
      do_op(3'd5, 32'h11, 32'd0, cyc);
      do_op(3'd6, 32'h22, 32'd0, cyc);
      do_op(3'd3, 32'd1234, 32'd0, cyc);
      n_total++;
      if (cyc != 10 || HI !== 32'h11 || LO !== 32'h22) begin
         $display("FAIL div_zero cycles=%0d HI=%h LO=%h required 10 11 22", cyc, HI, LO);
      end else n_pass++;
   endtask

   task automatic test_stall;
      int stalls;
      logic [63:0] m;
      @(negedge clk);
      d_md_use = 1'b1; start = 1'b1; md_op = 3'd1; A = 32'd6; B = 32'd7;
      #1;
      stalls = md_stall ? 1 : 0;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (md_stall) stalls++;
         @(posedge clk); #1;
      end
      m = model(3'd1, 32'd6, 32'd7, hi_m, lo_m);
      hi_m = m[63:32]; lo_m = m[31:0];
      n_total++;
      if (stalls != 6 || md_stall !== 1'b0) begin
         $display("FAIL stall_len stalls=%0d final=%b required 6 0", stalls, md_stall);
      end else n_pass++;
      n_total++;
      if (HI !== hi_m || LO !== lo_m) begin
         $display("FAIL stall_result HI=%h LO=%h required %h %h", HI, LO, hi_m, lo_m);
      end else n_pass++;
      d_md_use = 1'b0;
   endtask

   task automatic test_drop;
      logic [63:0] m;
      @(negedge clk);
      start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      repeat (7) @(posedge clk);
      #1;
      n_total++;
      if (drop !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL drop_pre drop=%b busy=%b required 0 1", drop, busy);
      end else n_pass++;
      @(negedge clk);
      start = 1'b1; md_op = 3'd3; A = 32'd5; B = 32'd1;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      n_total++;
      if (drop !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL drop_pulse drop=%b busy=%b required 1 1", drop, busy);
      end else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (drop !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL drop_clear drop=%b busy=%b required 0 1", drop, busy);
      end else n_pass++;
      @(posedge clk); #1;
      m = model(3'd3, 32'd100, 32'd7, hi_m, lo_m);
      hi_m = m[63:32]; lo_m = m[31:0];
      n_total++;
      if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
         $display("FAIL drop_commit busy=%b HI=%h LO=%h required 0 %h %h", busy, HI, LO, hi_m, lo_m);
      end else n_pass++;
   endtask

   task automatic test_mtlo;
      @(negedge clk);
      start = 1'b1; md_op = 3'd6; A = 32'h5A; B = 32'd0;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      lo_m = 32'h5A;
      n_total++;
      if (LO !== 32'h5A || HI !== hi_m || busy !== 1'b0) begin
         $display("FAIL mtlo LO=%h HI=%h busy=%b required 5a %h 0", LO, HI, busy, hi_m);
      end else n_pass++;
   endtask

   task automatic test_async_reset;
      int cyc;
      int bad;
      do_op(3'd5, 32'hABCD, 32'd0, cyc);
      @(negedge clk);
      start = 1'b1; md_op = 3'd3; A = 32'd1000; B = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      repeat (6) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         $display("FAIL async_reset busy=%b HI=%h LO=%h required 0 0 0", busy, HI, LO);
      end else n_pass++;
      @(negedge clk); reset = 1'b1;
      hi_m = 32'd0; lo_m = 32'd0;
      bad = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
      end
      n_total++;
      if (bad != 0) begin
         $display("FAIL post_reset_commit bad_cycles=%0d HI=%h LO=%h required 0 0 0", bad, HI, LO);
      end else n_pass++;
   endtask

   task automatic test_random;
      int cyc;
      logic [2:0] op;
      logic [31:0] a, b;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         do_op(op, a, b, cyc);
         n_total++;
         if (cyc != latency(op) || HI !== hi_m || LO !== lo_m) begin
            $display("FAIL random op=%0d a=%h b=%h cycles=%0d HI=%h LO=%h required %0d %h %h",
                     op, a, b, cyc, HI, LO, latency(op), hi_m, lo_m);
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_stall();
      test_drop();
      test_mtlo();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
